// File: rtl/snake_pkg.sv
// snake_pkg: shared turn encoding and debounce defaults for the snake game blocks
package snake_pkg;
  typedef enum logic {TURN_LEFT = 1'b0, TURN_RIGHT = 1'b1} turn_t;
  localparam int DEBOUNCE_BITS_DEFAULT = 18;
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: 2-FF synchronizer plus stable-time debouncer; pulses press on a debounced fall
module key_debouncer #(
  parameter int BITS = 4
) (
  input  logic clock_25,
  input  logic reset,
  input  logic key_n,
  output logic press
);
  logic r_meta, r_sync, r_stable;
  logic [BITS-1:0] r_cnt;
  logic w_flip;
  assign w_flip = (r_sync != r_stable) && (&r_cnt);
  assign press = w_flip && !r_sync;
  // any sample matching the stable level restarts the count, so bounces never accumulate
  always_ff @(posedge clock_25 or negedge reset)
    if (!reset) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_meta <= key_n;
      r_sync <= r_meta;
      r_cnt  <= (r_sync == r_stable || w_flip) ? '0 : r_cnt + BITS'(1);
      if (w_flip) r_stable <= r_sync;
    end
endmodule

// File: rtl/turn_input_queue.sv
// turn_input_queue: debounces the two turn keys and queues turns, one consumed per game_tik
module turn_input_queue
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_BITS = DEBOUNCE_BITS_DEFAULT,
  parameter int QUEUE_DEPTH   = 2
) (
  input  logic                             clock_25,
  input  logic                             reset,
  input  logic                             key_right_n,
  input  logic                             key_left_n,
  input  logic                             game_tik,
  input  logic                             sync_reset,
  output logic                             right_P,
  output logic                             left_P,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count,
  output logic                             dropped
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);
  logic w_press_r, w_press_l;
  key_debouncer #(.BITS(DEBOUNCE_BITS)) u_right (
    .clock_25(clock_25), .reset(reset), .key_n(key_right_n), .press(w_press_r)
  );
  key_debouncer #(.BITS(DEBOUNCE_BITS)) u_left (
    .clock_25(clock_25), .reset(reset), .key_n(key_left_n), .press(w_press_l)
  );
  turn_t r_mem [QUEUE_DEPTH];
  logic [PW-1:0] r_rd, r_wr, w_rd_n;
  logic [CW-1:0] r_count, w_count_n;
  logic r_right, r_left, r_dropped;
  logic w_one, w_pop, w_push, w_drop;
  turn_t w_turn, w_head;
  // when no older entry survives the pop, the new press itself becomes the head
  always_comb begin
    w_one     = w_press_r ^ w_press_l;
    w_turn    = w_press_r ? TURN_RIGHT : TURN_LEFT;
    w_pop     = game_tik && r_count != '0;
    w_push    = w_one && (r_count != FULL || w_pop);
    w_drop    = (w_press_r && w_press_l) || (w_one && !w_push);
    w_rd_n    = r_rd + PW'(w_pop);
    w_count_n = r_count + CW'(w_push) - CW'(w_pop);
    w_head    = (r_count == CW'(w_pop)) ? w_turn : r_mem[w_rd_n];
  end
  always_ff @(posedge clock_25)
    if (w_push && !sync_reset) r_mem[r_wr] <= w_turn;
  always_ff @(posedge clock_25 or negedge reset)
    if (!reset) begin
      r_rd      <= '0;
      r_wr      <= '0;
      r_count   <= '0;
      r_right   <= 1'b0;
      r_left    <= 1'b0;
      r_dropped <= 1'b0;
    end else if (sync_reset) begin
      r_rd      <= '0;
      r_wr      <= '0;
      r_count   <= '0;
      r_right   <= 1'b0;
      r_left    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_rd      <= w_rd_n;
      r_wr      <= r_wr + PW'(w_push);
      r_count   <= w_count_n;
      r_right   <= w_count_n != '0 && w_head == TURN_RIGHT;
      r_left    <= w_count_n != '0 && w_head == TURN_LEFT;
      r_dropped <= w_drop;
    end
  assign right_P     = r_right;
  assign left_P      = r_left;
  assign queue_count = r_count;
  assign dropped     = r_dropped;
endmodule

// File: tb/tb_turn_input_queue.sv
// tb_turn_input_queue: scoreboard bench; expected turns queued on press, compared at head/pop
module tb_turn_input_queue;
  logic clock_25 = 1'b0, reset = 1'b0;
  logic key_right_n = 1'b1, key_left_n = 1'b1, game_tik = 1'b0, sync_reset = 1'b0;
  logic right_P, left_P, dropped;
  logic [1:0] queue_count;
  int checks = 0, errors = 0;
  bit q[$];

  always #20 clock_25 = ~clock_25;

  turn_input_queue #(.DEBOUNCE_BITS(4), .QUEUE_DEPTH(2)) dut (
    .clock_25(clock_25), .reset(reset), .key_right_n(key_right_n), .key_left_n(key_left_n),
    .game_tik(game_tik), .sync_reset(sync_reset), .right_P(right_P), .left_P(left_P),
    .queue_count(queue_count), .dropped(dropped)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock_25);
    #1;
  endtask

  task automatic check_head(input string tag);
    check({tag, ".count"}, 32'(queue_count), 32'(q.size()));
    check({tag, ".right"}, 32'(right_P), 32'(q.size() > 0 && q[0]));
    check({tag, ".left"}, 32'(left_P), 32'(q.size() > 0 && !q[0]));
  endtask

  task automatic tik(input string tag);
    game_tik = 1'b1;
    step(1);
    game_tik = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    check_head(tag);
  endtask

  // keys go low just after an edge; the debounced push lands 18 edges later
  task automatic press(input string tag, input bit r, input bit l, input bit with_tik);
    bit drop;
    key_right_n = !r;
    key_left_n  = !l;
    step(17);
    check({tag, ".early"}, 32'(queue_count), 32'(q.size()));
    game_tik = with_tik;
    step(1);
    game_tik = 1'b0;
    if (with_tik && q.size() > 0) void'(q.pop_front());
    drop = (r && l) || q.size() == 2;
    if (!drop) q.push_back(r);
    check({tag, ".drop"}, 32'(dropped), 32'(drop));
    check_head(tag);
    step(1);
    check({tag, ".drop_end"}, 32'(dropped), 32'h0);
  endtask

  task automatic release_keys(input string tag);
    key_right_n = 1'b1;
    key_left_n  = 1'b1;
    step(22);
    check_head(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    step(2);
    check_head("reset");
    check("reset.drop", 32'(dropped), 32'h0);
    reset = 1'b1;
    step(2);

    press("clean", 1, 0, 0);
    step(20);
    release_keys("clean_rel");
    tik("clean_tik");
    step(5);
    check_head("clean_idle");

    for (int i = 0; i < 12; i++) begin
      key_left_n = (i % 2 == 1);
      step(5);
    end
    key_left_n = 1'b1;
    step(25);
    check_head("bounce");

    press("ovf1", 1, 0, 0); release_keys("ovf1_rel");
    press("ovf2", 0, 1, 0); release_keys("ovf2_rel");
    press("ovf3", 1, 0, 0); release_keys("ovf3_rel");
    tik("ovf_tik1");
    tik("ovf_tik2");
    tik("ovf_tik3");

    press("both", 1, 1, 0); release_keys("both_rel");

    press("full1", 1, 0, 0); release_keys("full1_rel");
    press("full2", 0, 1, 0); release_keys("full2_rel");
    press("full_tik", 1, 0, 1); release_keys("full_tik_rel");
    tik("full_pop1");
    tik("full_pop2");
    tik("full_pop3");

    press("empty_tik", 0, 1, 1); release_keys("empty_tik_rel");
    tik("empty_pop");

    press("sr1", 0, 1, 0); release_keys("sr1_rel");
    press("sr2", 1, 0, 0);
    sync_reset = 1'b1;
    step(1);
    sync_reset = 1'b0;
    q.delete();
    check_head("sync_reset");
    step(30);
    check_head("sync_held");
    release_keys("sync_rel");

    press("ar1", 0, 1, 0); release_keys("ar1_rel");
    key_right_n = 1'b0;
    step(10);
    #5 reset = 1'b0;
    #2;
    q.delete();
    check_head("async");
    check("async.drop", 32'(dropped), 32'h0);
    key_right_n = 1'b1;
    step(3);
    reset = 1'b1;
    step(30);
    check_head("async_after");
    check("async_after.drop", 32'(dropped), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
